fifo_rr_drain: RTL

//  Round-robin read-side scheduler for CHANNELS synchronous fifo instances sharing one sink (e.g. a bus or UART TX).

---
 rtl/fifo_rr_drain_pkg.sv | 9 +
 rtl/fifo_rr_drain_rr_pick.sv | 22 ++
 rtl/fifo_rr_drain.sv | 111 +++++++++++
 3 files changed

// File: rtl/fifo_rr_drain_pkg.sv
// Shared types for the round-robin fifo drain scheduler.
package fifo_rr_drain_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_e;

endpackage

// File: rtl/fifo_rr_drain_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick #(
   parameter int CHANNELS  = 4,
   parameter int CHAN_BITS = 2
) (
   input  logic [CHANNELS-1:0]  req,
   input  logic [CHAN_BITS-1:0] last,
   output logic                 any,
   output logic [CHAN_BITS-1:0] idx
);

   // Walk the distance backwards so the nearest requester after 'last' is written last.
   always_comb begin
      any = |req;
      idx = '0;
      for (int k = CHANNELS; k >= 1; k--) begin
         if (req[(int'(last) + k) % CHANNELS])
            idx = CHAN_BITS'((int'(last) + k) % CHANNELS);
      end
   end

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin read-side scheduler: drains up to BURST_MAX words per grant from
// CHANNELS fifos into one valid/ready sink, with a 1-cycle arbitration gap per switch.
module fifo_rr_drain
   import fifo_rr_drain_pkg::*;
#(
   parameter int CHANNELS   = 4,
   parameter int CHAN_BITS  = 2,
   parameter int DATA_BITS  = 32,
   parameter int BURST_MAX  = 4,
   parameter int BURST_BITS = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [CHANNELS-1:0]           ch_enable,
   input  logic [CHANNELS-1:0]           ch_empty,
   input  logic [CHANNELS-1:0]           ch_near_empty,
   input  logic [CHANNELS*DATA_BITS-1:0] ch_data,
   output logic [CHANNELS-1:0]           ch_en_r,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_BITS-1:0]          out_data,
   output logic [CHAN_BITS-1:0]          out_chan,
   output logic                          out_last,
   output logic                          busy
);

   state_e                state_q;
   logic [CHAN_BITS-1:0]  sel_q;
   logic [CHAN_BITS-1:0]  rr_last_q;
   logic [BURST_BITS-1:0] burst_cnt_q;
   logic [BURST_BITS-1:0] burst_cnt_d;

   logic [CHANNELS-1:0]   req;
   logic                  pick_any;
   logic [CHAN_BITS-1:0]  pick_idx;
   logic                  grant;
   logic                  sel_en, sel_empty, sel_near;
   logic [DATA_BITS-1:0]  sel_data;
   logic                  cur_valid, burst_end, pop;

   assign req = ch_enable & ~ch_empty;

   rr_pick #(.CHANNELS(CHANNELS), .CHAN_BITS(CHAN_BITS)) u_pick (
      .req  (req),
      .last (rr_last_q),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   always_comb begin
      sel_en    = 1'b0;
      sel_empty = 1'b1;
      sel_near  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sel_q == CHAN_BITS'(i)) begin
            sel_en    = ch_enable[i];
            sel_empty = ch_empty[i];
            sel_near  = ch_near_empty[i];
            sel_data  = ch_data[i*DATA_BITS +: DATA_BITS];
         end
      end
   end

   assign grant     = (state_q == S_GRANT);
   assign cur_valid = grant & sel_en & ~sel_empty;
   assign burst_end = (BURST_MAX != 0) && (burst_cnt_q == BURST_BITS'(BURST_MAX - 1));
   assign pop       = cur_valid & out_ready;

   assign out_valid = cur_valid;
   assign out_data  = cur_valid ? sel_data : '0;
   assign out_chan  = grant ? sel_q : '0;
   assign out_last  = cur_valid & (sel_near | burst_end);
   assign busy      = grant;

   // The pop strobe is same-cycle so back-to-back words need no wait states.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++)
         ch_en_r[i] = pop & (sel_q == CHAN_BITS'(i));
   end

   assign burst_cnt_d = burst_cnt_q + BURST_BITS'(pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sel_q       <= '0;
         rr_last_q   <= CHAN_BITS'(CHANNELS - 1);
         burst_cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pick_any) begin
                  state_q     <= S_GRANT;
                  sel_q       <= pick_idx;
                  rr_last_q   <= pick_idx;
                  burst_cnt_q <= '0;
               end
            end
            S_GRANT: begin
               burst_cnt_q <= burst_cnt_d;
               // A channel that empties or is disabled gives up its grant without a pop.
               if (!cur_valid || (pop && out_last))
                  state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
